// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and defaults for the bit-serial adder controller
package serial_add_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } sa_state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle between a requester and serial_add_ctrl
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit full adder built from two half adders and an OR on their carries
module full_adder_cell (
    input  wire a,
    input  wire b,
    input  wire ci,
    output wire s,
    output wire co
);

    wire w_s0;
    wire w_c0;
    wire w_c1;

    half_adder u_ha0 (.a(a),    .b(b),  .s(w_s0), .c(w_c0));
    half_adder u_ha1 (.a(w_s0), .b(ci), .s(s),    .c(w_c1));

    or g_or (co, w_c0, w_c1);

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - gate-level one-bit half adder
module half_adder (
    input  wire a,
    input  wire b,
    output wire s,
    output wire c
);

    xor g_xor (s, a, b);
    and g_and (c, a, b);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequences one full-adder cell LSB-first across WIDTH-bit operands
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        r_state;
    sa_state_t        w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_c;
    logic             w_last;

    full_adder_cell u_fa (
        .a  (r_opa[0]),
        .b  (r_opb[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_c)
    );

    assign w_last = (r_cnt == LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // busy/done are flopped from the next state so they launch from registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_sr    <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_opa   <= bus.a;
                        r_opb   <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sr    <= {w_s, r_sr[WIDTH-1:1]};
                    r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
                    r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
                    r_carry <= w_c;
                    // hold at the last count; the counter is reloaded on the next accept
                    if (w_last) begin
                        r_sum  <= {w_s, r_sr[WIDTH-1:1]};
                        r_cout <= w_c;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl with directed vectors
module tb_serial_add_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    exp_t         q[$];
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         done_prev;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("reset_outputs", {22'd0, bus.busy, bus.done, bus.cout, bus.sum}, 32'd0);
            m_sum     = '0;
            m_cout    = 1'b0;
            done_prev = 1'b0;
        end else if (bus.done) begin
            chk("done_single_cycle", {31'd0, done_prev}, 32'd0);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("result_sum",  {24'd0, bus.sum},  {24'd0, e.sum});
                chk("result_cout", {31'd0, bus.cout}, {31'd0, e.cout});
                chk("done_cycle",  cyc, e.due);
                m_sum  = e.sum;
                m_cout = e.cout;
            end
            done_prev = 1'b1;
        end else begin
            chk("result_hold", {23'd0, bus.cout, bus.sum}, {23'd0, m_cout, m_sum});
            done_prev = 1'b0;
        end
    end

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        bus.a   = a;
        bus.b   = b;
        bus.cin = ci;
    endtask

    task automatic accept(input logic [W-1:0] s, input logic co);
        exp_t e;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        e.sum  = s;
        e.cout = co;
        e.due  = cyc + W;
        q.push_back(e);
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] s, input logic co);
        set_ops(a, b, ci);
        accept(s, co);
        bus.start = 1'b0;
        repeat (W + 1) @(posedge clk);
        #1;
        chk("busy_fall", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_sum     = '0;
        m_cout    = 1'b0;
        done_prev = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        set_ops('0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // start pulses at E3 and in the DONE cycle must be ignored
        set_ops(8'h10, 8'h20, 1'b0);
        accept(8'h30, 1'b0);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        set_ops(8'h77, 8'h77, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_fall_after_ignored", {31'd0, bus.busy}, 32'd0);
        repeat (12) @(posedge clk);
        #1;

        // reset in the middle of RUN discards the operation
        set_ops(8'hAB, 8'hCD, 1'b1);
        accept(8'h79, 1'b1);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("busy_in_reset", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

        // start held high: accepts every W+2 cycles with operands changing meanwhile
        set_ops(8'h80, 8'h80, 1'b0);
        accept(8'h00, 1'b1);
        set_ops(8'h7F, 8'h01, 1'b1);
        repeat (W + 1) @(posedge clk);
        accept(8'h81, 1'b0);
        set_ops(8'hAA, 8'h55, 1'b0);
        repeat (W + 1) @(posedge clk);
        accept(8'hFF, 1'b0);
        set_ops(8'hC3, 8'h3C, 1'b1);
        repeat (W + 1) @(posedge clk);
        accept(8'h00, 1'b1);
        bus.start = 1'b0;
        set_ops(8'h99, 8'h99, 1'b1);
        repeat (W + 6) @(posedge clk);
        #1;

        chk("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
